// File: rtl/prio_scan_pkg.sv
// Shared types and constants for the sequential priority scan encoder.
package prio_scan_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        NONE = 2'd2
    } state_t;

    localparam logic ORDER_MSB = 1'b0;
    localparam logic ORDER_LSB = 1'b1;

endpackage

// File: rtl/prio_find.sv
// Combinational search for the highest or lowest set bit of a vector,
// plus flags for "any bit set" and "exactly one bit set".
module prio_find
    import prio_scan_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    input  logic             lsb_first,
    output logic [IDX_W-1:0] idx,
    output logic             found,
    output logic             single
);

    always_comb begin
        idx    = '0;
        found  = |vec;
        single = found && ((vec & (vec - WIDTH'(1))) == '0);
        // The last match written wins, so the loop direction picks the end.
        if (lsb_first == ORDER_LSB) begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (vec[i]) idx = IDX_W'(i);
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (vec[i]) idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/prio_scan_encoder.sv
// Sequential priority encoder: emits one index beat per set bit of an accepted
// vector. Define PRIO_SCAN_POPCNT_EN to add the out_remain bit counter.
//
// state | meaning
// IDLE  | waiting for a request vector, in_ready=1
// SCAN  | emitting one beat per remaining set bit of the work register
// NONE  | single "no index" beat for an all-zero vector
module prio_scan_encoder
    import prio_scan_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vec,
    input  logic             in_lsb_first,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             out_none,
    output logic             busy
`ifdef PRIO_SCAN_POPCNT_EN
    ,
    output logic [IDX_W:0]   out_remain
`endif
);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] work;
    logic             order;
    logic [IDX_W-1:0] find_idx;
    logic             find_found;
    logic             find_single;
    logic             accept;
    logic             beat_take;

    prio_find #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_find (
        .vec       (work),
        .lsb_first (order),
        .idx       (find_idx),
        .found     (find_found),
        .single    (find_single)
    );

    assign accept    = in_valid && (state == IDLE);
    assign beat_take = (state == SCAN) && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work  <= '0;
            order <= ORDER_MSB;
        end else if (accept) begin
            work  <= in_vec;
            order <= in_lsb_first;
        end else if (beat_take) begin
            work  <= work & ~(WIDTH'(1) << find_idx);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = (in_vec != '0) ? SCAN : NONE;
            SCAN:    if (out_ready && find_single) state_nxt = IDLE;
            NONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_idx   = '0;
        out_last  = 1'b0;
        out_none  = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            SCAN: begin
                out_valid = 1'b1;
                out_idx   = find_found ? find_idx : '0;
                out_last  = find_single;
            end
            NONE: begin
                out_valid = 1'b1;
                out_last  = 1'b1;
                out_none  = 1'b1;
            end
            default: busy = 1'b0;
        endcase
    end

`ifdef PRIO_SCAN_POPCNT_EN
    logic [IDX_W:0] remain;

    function automatic logic [IDX_W:0] popcount(input logic [WIDTH-1:0] v);
        logic [IDX_W:0] cnt;
        cnt = '0;
        for (int i = 0; i < WIDTH; i++) cnt = cnt + (IDX_W + 1)'(v[i]);
        return cnt;
    endfunction

    // Reaches zero on the final SCAN beat, so IDLE and NONE read 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         remain <= '0;
        else if (accept)    remain <= popcount(in_vec);
        else if (beat_take) remain <= remain - 1'b1;
    end

    assign out_remain = remain;
`endif

endmodule

// File: tb/tb_prio_scan_encoder.sv
// Scoreboard bench for prio_scan_encoder: accepted vectors are expanded into
// expected beats by a set-bit list model; a monitor pops and compares beats.
module tb_prio_scan_encoder;

    localparam int WIDTH = 16;
    localparam int IDX_W = 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_vec;
    logic             in_lsb_first;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_idx;
    logic             out_last;
    logic             out_none;
    logic             busy;
`ifdef PRIO_SCAN_POPCNT_EN
    logic [IDX_W:0]   out_remain;
`endif

    prio_scan_encoder #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_vec       (in_vec),
        .in_lsb_first (in_lsb_first),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_idx      (out_idx),
        .out_last     (out_last),
        .out_none     (out_none),
        .busy         (busy)
`ifdef PRIO_SCAN_POPCNT_EN
        ,
        .out_remain   (out_remain)
`endif
    );

    typedef struct {
        int idx;
        bit last;
        bit none;
        int remain;
    } beat_t;

    beat_t exp_q[$];
    int    checks   = 0;
    int    failures = 0;
    int    beat_cnt = 0;
    int    rdy_mode = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // Reference: list the set bits in scan order, one beat each.
    function automatic void expect_vector(logic [WIDTH-1:0] v, bit lsb);
        int idxs[$];
        for (int i = 0; i < WIDTH; i++) begin
            if (((v >> i) & 1) == 1) begin
                if (lsb) idxs.push_back(i);
                else     idxs.push_front(i);
            end
        end
        if (idxs.size() == 0) begin
            exp_q.push_back('{idx: 0, last: 1'b1, none: 1'b1, remain: 0});
        end else begin
            for (int k = 0; k < idxs.size(); k++)
                exp_q.push_back('{idx: idxs[k], last: (k == idxs.size() - 1),
                                  none: 1'b0, remain: idxs.size() - k});
        end
    endfunction

    // Accept tracker
    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready) expect_vector(in_vec, in_lsb_first);
    end

    // Beat monitor
    bit               stall_prev = 0;
    bit               ready_chk  = 0;
    logic [IDX_W-1:0] held_idx;
    logic             held_last;
    logic             held_none;

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 0;
            ready_chk  = 0;
        end else begin
            if (ready_chk) begin
                check("in_ready_after_last", in_ready, 1);
`ifdef PRIO_SCAN_POPCNT_EN
                check("remain_idle", out_remain, 0);
`endif
                ready_chk = 0;
            end
            if (out_valid) begin
                if (stall_prev)
                    check("stall_hold", {out_idx, out_last, out_none},
                          {held_idx, held_last, held_none});
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_beat actual idx=%0d none=%0d required=no beat",
                                 out_idx, out_none);
                    end else begin
                        beat_t e;
                        e = exp_q.pop_front();
                        check("beat_idx", out_idx, e.idx);
                        check("beat_last", out_last, e.last);
                        check("beat_none", out_none, e.none);
`ifdef PRIO_SCAN_POPCNT_EN
                        check("beat_remain", out_remain, e.remain);
`endif
                    end
                    beat_cnt++;
                    if (out_last) ready_chk = 1;
                    stall_prev = 0;
                end else begin
                    stall_prev = 1;
                    held_idx   = out_idx;
                    held_last  = out_last;
                    held_none  = out_none;
                end
            end else begin
                stall_prev = 0;
            end
        end
    end

    // Downstream ready pattern
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ~out_ready;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(logic [WIDTH-1:0] v, bit lsb);
        int n = 0;
        while (!in_ready && n < 300) begin
            step();
            n++;
        end
        if (n >= 300) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual in_ready=0 required=1");
        end
        in_valid     = 1'b1;
        in_vec       = v;
        in_lsb_first = lsb;
        step();
        in_valid = 1'b0;
        in_vec   = 16'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || !in_ready) && n < 500) begin
            step();
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        int base;
        logic [WIDTH-1:0] v;
        in_valid     = 1'b0;
        in_vec       = '0;
        in_lsb_first = 1'b0;
        rst_n        = 1'b0;
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_idx_last_none", {out_idx, out_last, out_none}, 0);
        #5 rst_n = 1'b1;
        step();

        // two set bits, MSB first: in_ready low for exactly two cycles
        rdy_mode = 0;
        send(16'h8001, 1'b0);
        check("busy_window0", in_ready, 0);
        step();
        check("busy_window1", in_ready, 0);
        step();
        check("busy_window_end", in_ready, 1);
        drain();

        send(16'h0000, 1'b0);
        drain();

        rdy_mode = 1;
        send(16'hFFFF, 1'b1);
        drain();
        rdy_mode = 0;

        // in_valid kept high with changing data during SCAN must not re-accept
        send(16'h0F00, 1'b0);
        in_valid = 1'b1;
        repeat (3) begin
            in_vec       = 16'($urandom);
            in_lsb_first = 1'($urandom_range(0, 1));
            step();
        end
        in_valid = 1'b0;
        drain();

        send(16'h0700, 1'b0);
        drain();

        // reset in the middle of a vector
        base = beat_cnt;
        send(16'h00F0, 1'b0);
        for (int n = 0; n < 50 && beat_cnt < base + 2; n++) begin
            @(negedge clk);
            #1;
        end
        check("beats_before_reset", beat_cnt - base, 2);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_in_ready", in_ready, 1);
        exp_q.delete();
        @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (6) step();
        check("post_rst_idle", {out_valid, busy, in_ready}, 3'b001);

        // randomized vectors, orders and backpressure
        for (int t = 0; t < 60; t++) begin
            rdy_mode = $urandom_range(0, 2);
            case ($urandom_range(0, 5))
                0:       v = '0;
                1:       v = '1;
                2:       v = 16'(1 << $urandom_range(0, WIDTH - 1));
                3:       v = 16'($urandom) & 16'($urandom);
                default: v = 16'($urandom);
            endcase
            send(v, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) drain();
        end
        rdy_mode = 0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
